// File: rtl/seq_comparator_pkg.sv
// Shared FSM state encoding and the slice-index width helper for seq_comparator.
package seq_comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Index register needs at least one bit even when there is a single slice.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_comparator_chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
module chunk_compare #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator: one CHUNK slice per clock, early exit
// on the first differing slice, signed mode handled by biasing the sign bits.
module seq_comparator
    import seq_comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0]  LAST     = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    state_t          state, state_nx;
    logic [IDXW-1:0] idx;
    // Ascending packed range puts slice 0 at the MSB end, so idx selects directly.
    logic [0:NCHUNK-1][CHUNK-1:0] a_q, b_q;
    logic            slice_gt, slice_eq, finish;

    chunk_compare #(.CHUNK(CHUNK)) u_cmp (
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .gt (slice_gt),
        .eq (slice_eq)
    );

    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        case (state)
            IDLE: if (start) state_nx = CMP;
            CMP: begin
                if (!slice_eq || idx == LAST) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            idx  <= '0;
            done <= 1'b0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            done <= finish;
            if (state == IDLE && start) begin
                // Flipping both sign bits maps two's-complement order onto unsigned order.
                a_q <= a ^ (signed_mode ? SIGN_BIT : '0);
                b_q <= b ^ (signed_mode ? SIGN_BIT : '0);
                idx <= '0;
            end else if (state == CMP && !finish) begin
                idx <= idx + 1'b1;
            end
            if (finish) begin
                gt <= slice_gt;
                eq <= slice_eq;
                lt <= !slice_gt && !slice_eq;
            end
        end
    end

    assign busy = (state == CMP);

endmodule

// File: tb/tb_seq_comparator.sv
// Directed table-driven bench for seq_comparator plus handshake, reset and NCHUNK=1 cases.
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, signed_mode;
    logic [31:0] a, b;
    logic        busy, done, gt, eq, lt;

    logic        start2, signed_mode2;
    logic [15:0] a2, b2;
    logic        busy2, done2, gt2, eq2, lt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_comparator #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    seq_comparator #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(signed_mode2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        int          lat;
        logic        gt, eq, lt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with start low; ends at a negedge one cycle after done.
    task automatic run1(input string name, input vec_t v);
        int  lat, bcnt;
        bit  seen;
        a = v.a; b = v.b; signed_mode = v.sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs mid-compare; latched copies must be unaffected.
        a = ~v.a; b = ~v.b; signed_mode = ~v.sm;
        lat = 0; bcnt = 0; seen = 0;
        @(negedge clk);
        if (busy) bcnt++;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) bcnt++;
        end
        chk({name, " latency"}, lat, v.lat);
        chk({name, " busy_cycles"}, bcnt, v.lat);
        chk({name, " busy_at_done"}, busy, 1'b0);
        chk({name, " gt"}, gt, v.gt);
        chk({name, " eq"}, eq, v.eq);
        chk({name, " lt"}, lt, v.lt);
        @(negedge clk);
        chk({name, " done_single"}, done, 1'b0);
    endtask

    task automatic run2(input string name, input logic [15:0] x, input logic [15:0] y,
                        input logic sm, input logic egt, input logic eeq, input logic elt);
        a2 = x; b2 = y; signed_mode2 = sm; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        @(negedge clk);
        chk({name, " busy"}, busy2, 1'b1);
        @(negedge clk);
        chk({name, " done"}, done2, 1'b1);
        chk({name, " gt"}, gt2, egt);
        chk({name, " eq"}, eq2, eeq);
        chk({name, " lt"}, lt2, elt);
    endtask

    initial begin
        int  lat;
        bit  seen;

        vecs[0] = '{32'h33333333, 32'h33333333, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h44444444, 32'h22222222, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h12345678, 32'h12345679, 1'b0, 4, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h12340000, 32'h12FF0000, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 4, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'hFFFFFF80, 32'hFFFFFF7F, 1'b1, 4, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'hAB000000, 32'hAB00FF00, 1'b1, 3, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        start2 = 1'b0; signed_mode2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset gtqlt", {gt, eq, lt}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        chk("idle busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) run1($sformatf("vec%0d", i), vecs[i]);

        // Start while busy is ignored; then a start in the done cycle is accepted.
        a = 32'h33333333; b = 32'h33333333; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 32'h00000001; b = 32'h44444444; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk("hs latency", lat, 4);
        chk("hs eq", {gt, eq, lt}, 3'b010);
        a = 32'h44444444; b = 32'h22222222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("hs2 accepted busy", busy, 1'b1);
        chk("hs2 done low", done, 1'b0);
        chk("hs2 held eq", {gt, eq, lt}, 3'b010);
        @(negedge clk);
        chk("hs2 done", done, 1'b1);
        chk("hs2 gt", {gt, eq, lt}, 3'b100);
        @(negedge clk);

        // Reset mid-compare aborts with no done pulse.
        a = 32'h33333333; b = 32'h33333333; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort gtqlt", {gt, eq, lt}, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort quiet", seen, 1'b0);

        run2("n1 lt", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
        run2("n1 signed", 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        run2("n1 unsigned", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        run2("n1 eq", 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_comparator.md
Name: seq_comparator

Overview:
- Parametrised multi-cycle magnitude comparator: successor to the 32-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, one CHUNK-bit slice per clock, and stops early at the first differing slice.
- Runtime signed/unsigned mode; start/busy/done handshake; produces gt/eq/lt.
- Sits beside the ALU datapath for wide compares where a full-width combinational compare is too slow.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; NCHUNK = WIDTH/CHUNK, must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a compare; sampled only when busy=0
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start
- a  input  WIDTH  operand 1; latched with start
- b  input  WIDTH  operand 2; latched with start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when results update
- gt  output  1  a > b; held until the next done
- eq  output  1  a == b; held until the next done
- lt  output  1  a < b; held until the next done

Behaviour:
- Reset, asynchronous: state=IDLE; busy, done, gt, eq and lt all 0; slice index=0; latched operands cleared.
- States:
  - IDLE: if start=1 at a clock edge, latch a, b and signed_mode, set idx=0 and busy=1, and go to CMP. Otherwise stay in IDLE.
  - CMP: each edge, compare slice idx (idx 0 = most-significant CHUNK bits) of the latched operands, unsigned.
    - If the slices differ, or idx = NCHUNK-1: load gt/eq/lt from that slice's result, pulse done=1 for the following cycle, set busy=0, go to IDLE.
    - Otherwise increment idx and stay in CMP.
- Signed handling: when latching with signed_mode=1, invert bit WIDTH-1 of both operands. An unsigned compare of the biased values then gives the signed ordering. No other datapath difference.
- Latency:
  - If the first differing slice is k, done is high in the cycle after edge k+1, counted from the start-sampling edge (edge 0).
  - Equal operands take NCHUNK compare edges. For the defaults, done arrives 4 edges after start.
  - Best case (MSB slice differs) is 1 edge.
- Exactly one of gt/eq/lt is 1 after any completed compare. All three are 0 only from reset until the first done.
- done is high for exactly one cycle. busy=0 in the same cycle done=1, so a new start can be accepted during the done cycle.
- start while busy=1 is ignored: no re-latch, no effect on the ongoing compare.
- Input changes on a, b or signed_mode while busy have no effect.
- Reset asserted mid-compare aborts immediately: no done pulse, and outputs return to reset values.
- NCHUNK=1 degenerates to a 1-cycle registered compare. The FSM must still work in this case, with idx width clamped to at least 1 bit.
- gt/eq/lt change only on the edge that raises done.

Decomposition:
- Shared include file holds the FSM state localparams (IDLE, CMP) and the clog2-style idx-width constant function.
- One natural sub-module, chunk_compare: parametrised by CHUNK, combinational unsigned slice compare giving gt and eq.
- seq_comparator instantiates it once and muxes the slice by idx.

Test Plan:
- Equal: reset, then start with a=32'h33333333, b=32'h33333333, signed_mode=0 → done after 4 edges with eq=1, gt=0, lt=0; busy high for exactly 4 cycles.
- Early exit: a=32'h44444444, b=32'h22222222, unsigned → done after 1 edge with gt=1, eq=0, lt=0.
- Last-slice difference: a=32'h12345678, b=32'h12345679 → done after 4 edges with lt=1.
- Signed vs unsigned: a=32'hFFFFFFFF, b=32'h00000001.
  - signed_mode=1 → lt=1 after 1 edge.
  - Repeat with signed_mode=0 → gt=1.
  - Also signed a=32'h80000000 vs b=32'h7FFFFFFF → lt=1.
- Handshake: pulse start again on edge 1 of the first equal compare, with different operands → ignored; result still eq=1 at edge 4. Then start is accepted in the done cycle and its result follows.
- Reset mid-op: start the equal compare, assert reset at edge 2 → busy=0, done never pulses, gt=eq=lt=0. Rerun WIDTH=16, CHUNK=16 with a=16'h0001, b=16'h0002 → lt=1 after 1 edge.
